// File: rtl/axi_region_demux_pkg.sv
// Shared response codes and FSM state types for the AXI region demultiplexer
// and its default (DECERR) slave.
package axi_region_demux_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_default_slave.sv
// DECERR responder for unmapped accesses: swallows write data, answers with one
// DECERR B beat, and returns ARLEN+1 zero-data DECERR read beats.
module axi_default_slave
    import axi_region_demux_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic                      w_last,
    input  logic                      w_valid,
    output logic                      w_ready,
    output logic [AXI_ID_WIDTH-1:0]   b_id,
    output logic [1:0]                b_resp,
    output logic                      b_valid,
    input  logic                      b_ready,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id,
    input  logic [7:0]                ar_len,
    input  logic                      ar_valid,
    output logic                      ar_ready,
    output logic [AXI_ID_WIDTH-1:0]   r_id,
    output logic [AXI_DATA_WIDTH-1:0] r_data,
    output logic [1:0]                r_resp,
    output logic                      r_last,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic                      b_done_o,
    output logic                      r_done_o
);

    w_state_e                  w_state_q, w_state_d;
    r_state_e                  r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [7:0]                r_cnt_q, r_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            b_id_q    <= '0;
            r_id_q    <= '0;
            r_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            b_id_q    <= b_id_d;
            r_id_q    <= r_id_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Ready is constant per state, so a valid alone implies the handshake.
    always_comb begin
        w_state_d = w_state_q;
        b_id_d    = b_id_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_valid) begin
                    w_state_d = W_DATA;
                    b_id_d    = aw_id;
                end
            end
            W_DATA: if (w_valid && w_last) w_state_d = W_RESP;
            W_RESP: if (b_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_valid) begin
                    r_state_d = R_DATA;
                    r_id_d    = ar_id;
                    r_cnt_d   = ar_len;
                end
            end
            R_DATA: begin
                if (r_ready) begin
                    if (r_cnt_q == 8'd0) r_state_d = R_IDLE;
                    else                 r_cnt_d   = r_cnt_q - 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = (w_state_q == W_IDLE);
        w_ready  = (w_state_q == W_DATA);
        b_valid  = (w_state_q == W_RESP);
        ar_ready = (r_state_q == R_IDLE);
        r_valid  = (r_state_q == R_DATA);
        r_last   = (r_state_q == R_DATA) && (r_cnt_q == 8'd0);
    end

    assign b_id     = b_id_q;
    assign b_resp   = RESP_DECERR;
    assign r_id     = r_id_q;
    assign r_data   = '0;
    assign r_resp   = RESP_DECERR;
    assign b_done_o = b_valid && b_ready;
    assign r_done_o = r_valid && r_ready && r_last;

endmodule

// File: rtl/axi_region_demux.sv
// One-to-N AXI4 address demultiplexer with independent read/write routing and
// a built-in DECERR default slave whose completions are counted.
module axi_region_demux
    import axi_region_demux_pkg::*;
#(
    parameter int NB_MASTER      = 3,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [AXI_ID_WIDTH-1:0]                       slv_aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]                     slv_aw_addr,
    input  logic [7:0]                                    slv_aw_len,
    input  logic [2:0]                                    slv_aw_size,
    input  logic [1:0]                                    slv_aw_burst,
    input  logic [2:0]                                    slv_aw_prot,
    input  logic [AXI_USER_WIDTH-1:0]                     slv_aw_user,
    input  logic                                          slv_aw_valid,
    output logic                                          slv_aw_ready,
    input  logic [AXI_DATA_WIDTH-1:0]                     slv_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]                   slv_w_strb,
    input  logic                                          slv_w_last,
    input  logic [AXI_USER_WIDTH-1:0]                     slv_w_user,
    input  logic                                          slv_w_valid,
    output logic                                          slv_w_ready,
    output logic [AXI_ID_WIDTH-1:0]                       slv_b_id,
    output logic [1:0]                                    slv_b_resp,
    output logic [AXI_USER_WIDTH-1:0]                     slv_b_user,
    output logic                                          slv_b_valid,
    input  logic                                          slv_b_ready,
    input  logic [AXI_ID_WIDTH-1:0]                       slv_ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]                     slv_ar_addr,
    input  logic [7:0]                                    slv_ar_len,
    input  logic [2:0]                                    slv_ar_size,
    input  logic [1:0]                                    slv_ar_burst,
    input  logic [2:0]                                    slv_ar_prot,
    input  logic [AXI_USER_WIDTH-1:0]                     slv_ar_user,
    input  logic                                          slv_ar_valid,
    output logic                                          slv_ar_ready,
    output logic [AXI_ID_WIDTH-1:0]                       slv_r_id,
    output logic [AXI_DATA_WIDTH-1:0]                     slv_r_data,
    output logic [1:0]                                    slv_r_resp,
    output logic                                          slv_r_last,
    output logic [AXI_USER_WIDTH-1:0]                     slv_r_user,
    output logic                                          slv_r_valid,
    input  logic                                          slv_r_ready,
    output logic [NB_MASTER-1:0][AXI_ID_WIDTH-1:0]        mst_aw_id,
    output logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0]      mst_aw_addr,
    output logic [NB_MASTER-1:0][7:0]                     mst_aw_len,
    output logic [NB_MASTER-1:0][2:0]                     mst_aw_size,
    output logic [NB_MASTER-1:0][1:0]                     mst_aw_burst,
    output logic [NB_MASTER-1:0][2:0]                     mst_aw_prot,
    output logic [NB_MASTER-1:0][AXI_USER_WIDTH-1:0]      mst_aw_user,
    output logic [NB_MASTER-1:0]                          mst_aw_valid,
    input  logic [NB_MASTER-1:0]                          mst_aw_ready,
    output logic [NB_MASTER-1:0][AXI_DATA_WIDTH-1:0]      mst_w_data,
    output logic [NB_MASTER-1:0][AXI_DATA_WIDTH/8-1:0]    mst_w_strb,
    output logic [NB_MASTER-1:0]                          mst_w_last,
    output logic [NB_MASTER-1:0][AXI_USER_WIDTH-1:0]      mst_w_user,
    output logic [NB_MASTER-1:0]                          mst_w_valid,
    input  logic [NB_MASTER-1:0]                          mst_w_ready,
    input  logic [NB_MASTER-1:0][AXI_ID_WIDTH-1:0]        mst_b_id,
    input  logic [NB_MASTER-1:0][1:0]                     mst_b_resp,
    input  logic [NB_MASTER-1:0][AXI_USER_WIDTH-1:0]      mst_b_user,
    input  logic [NB_MASTER-1:0]                          mst_b_valid,
    output logic [NB_MASTER-1:0]                          mst_b_ready,
    output logic [NB_MASTER-1:0][AXI_ID_WIDTH-1:0]        mst_ar_id,
    output logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0]      mst_ar_addr,
    output logic [NB_MASTER-1:0][7:0]                     mst_ar_len,
    output logic [NB_MASTER-1:0][2:0]                     mst_ar_size,
    output logic [NB_MASTER-1:0][1:0]                     mst_ar_burst,
    output logic [NB_MASTER-1:0][2:0]                     mst_ar_prot,
    output logic [NB_MASTER-1:0][AXI_USER_WIDTH-1:0]      mst_ar_user,
    output logic [NB_MASTER-1:0]                          mst_ar_valid,
    input  logic [NB_MASTER-1:0]                          mst_ar_ready,
    input  logic [NB_MASTER-1:0][AXI_ID_WIDTH-1:0]        mst_r_id,
    input  logic [NB_MASTER-1:0][AXI_DATA_WIDTH-1:0]      mst_r_data,
    input  logic [NB_MASTER-1:0][1:0]                     mst_r_resp,
    input  logic [NB_MASTER-1:0]                          mst_r_last,
    input  logic [NB_MASTER-1:0][AXI_USER_WIDTH-1:0]      mst_r_user,
    input  logic [NB_MASTER-1:0]                          mst_r_valid,
    output logic [NB_MASTER-1:0]                          mst_r_ready,
    input  logic [NB_MASTER*AXI_ADDR_WIDTH-1:0]           start_addr_i,
    input  logic [NB_MASTER*AXI_ADDR_WIDTH-1:0]           end_addr_i,
    output logic [15:0]                                   decerr_cnt_o
);

    localparam int              IDX_W   = $clog2(NB_MASTER + 1);
    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(NB_MASTER);

    // Index NB_MASTER means "default slave"; scanning downwards lets the lowest
    // matching region win on overlap.
    function automatic logic [IDX_W-1:0] decode(
        input logic [AXI_ADDR_WIDTH-1:0]           addr,
        input logic [NB_MASTER*AXI_ADDR_WIDTH-1:0] starts,
        input logic [NB_MASTER*AXI_ADDR_WIDTH-1:0] ends
    );
        logic [IDX_W-1:0] idx;
        idx = DEF_IDX;
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if (addr >= starts[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] &&
                addr <= ends[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    w_state_e                w_state_q, w_state_d;
    r_state_e                r_state_q, r_state_d;
    logic [IDX_W-1:0]        w_idx_q, w_idx_d;
    logic [IDX_W-1:0]        r_idx_q, r_idx_d;
    logic [15:0]             decerr_cnt_q, decerr_cnt_d;
    logic [16:0]             cnt_sum;
    logic [IDX_W-1:0]        aw_dec, ar_dec;

    logic                    def_aw_valid, def_aw_ready, def_w_valid, def_w_ready;
    logic                    def_b_valid, def_b_ready, def_ar_valid, def_ar_ready;
    logic                    def_r_valid, def_r_ready, def_r_last;
    logic                    def_b_done, def_r_done;
    logic [AXI_ID_WIDTH-1:0] def_b_id, def_r_id;
    logic [1:0]              def_b_resp, def_r_resp;
    logic [AXI_DATA_WIDTH-1:0] def_r_data;

    assign aw_dec = decode(slv_aw_addr, start_addr_i, end_addr_i);
    assign ar_dec = decode(slv_ar_addr, start_addr_i, end_addr_i);

    // Request payloads fan out to every port; only the valids are steered.
    for (genvar g = 0; g < NB_MASTER; g++) begin : g_bcast
        assign mst_aw_id[g]    = slv_aw_id;
        assign mst_aw_addr[g]  = slv_aw_addr;
        assign mst_aw_len[g]   = slv_aw_len;
        assign mst_aw_size[g]  = slv_aw_size;
        assign mst_aw_burst[g] = slv_aw_burst;
        assign mst_aw_prot[g]  = slv_aw_prot;
        assign mst_aw_user[g]  = slv_aw_user;
        assign mst_w_data[g]   = slv_w_data;
        assign mst_w_strb[g]   = slv_w_strb;
        assign mst_w_last[g]   = slv_w_last;
        assign mst_w_user[g]   = slv_w_user;
        assign mst_ar_id[g]    = slv_ar_id;
        assign mst_ar_addr[g]  = slv_ar_addr;
        assign mst_ar_len[g]   = slv_ar_len;
        assign mst_ar_size[g]  = slv_ar_size;
        assign mst_ar_burst[g] = slv_ar_burst;
        assign mst_ar_prot[g]  = slv_ar_prot;
        assign mst_ar_user[g]  = slv_ar_user;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            w_idx_q      <= '0;
            r_idx_q      <= '0;
            decerr_cnt_q <= '0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            w_idx_q      <= w_idx_d;
            r_idx_q      <= r_idx_d;
            decerr_cnt_q <= decerr_cnt_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        case (w_state_q)
            W_IDLE: begin
                if (slv_aw_valid && slv_aw_ready) begin
                    w_state_d = W_DATA;
                    w_idx_d   = aw_dec;
                end
            end
            W_DATA: if (slv_w_valid && slv_w_ready && slv_w_last) w_state_d = W_RESP;
            W_RESP: if (slv_b_valid && slv_b_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        case (r_state_q)
            R_IDLE: begin
                if (slv_ar_valid && slv_ar_ready) begin
                    r_state_d = R_DATA;
                    r_idx_d   = ar_dec;
                end
            end
            R_DATA: if (slv_r_valid && slv_r_ready && slv_r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Handshake signals are forced low while reset is asserted.
    always_comb begin
        slv_aw_ready = 1'b0;
        slv_w_ready  = 1'b0;
        slv_b_valid  = 1'b0;
        slv_b_id     = '0;
        slv_b_resp   = RESP_OKAY;
        slv_b_user   = '0;
        mst_aw_valid = '0;
        mst_w_valid  = '0;
        mst_b_ready  = '0;
        def_aw_valid = 1'b0;
        def_w_valid  = 1'b0;
        def_b_ready  = 1'b0;
        if (rst_n) begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_dec == DEF_IDX) begin
                        def_aw_valid = slv_aw_valid;
                        slv_aw_ready = def_aw_ready;
                    end
                    for (int i = 0; i < NB_MASTER; i++) begin
                        if (aw_dec == IDX_W'(i)) begin
                            mst_aw_valid[i] = slv_aw_valid;
                            slv_aw_ready    = mst_aw_ready[i];
                        end
                    end
                end
                W_DATA: begin
                    if (w_idx_q == DEF_IDX) begin
                        def_w_valid = slv_w_valid;
                        slv_w_ready = def_w_ready;
                    end
                    for (int i = 0; i < NB_MASTER; i++) begin
                        if (w_idx_q == IDX_W'(i)) begin
                            mst_w_valid[i] = slv_w_valid;
                            slv_w_ready    = mst_w_ready[i];
                        end
                    end
                end
                W_RESP: begin
                    if (w_idx_q == DEF_IDX) begin
                        def_b_ready = slv_b_ready;
                        slv_b_valid = def_b_valid;
                        slv_b_id    = def_b_id;
                        slv_b_resp  = def_b_resp;
                    end
                    for (int i = 0; i < NB_MASTER; i++) begin
                        if (w_idx_q == IDX_W'(i)) begin
                            mst_b_ready[i] = slv_b_ready;
                            slv_b_valid    = mst_b_valid[i];
                            slv_b_id       = mst_b_id[i];
                            slv_b_resp     = mst_b_resp[i];
                            slv_b_user     = mst_b_user[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        slv_ar_ready = 1'b0;
        slv_r_valid  = 1'b0;
        slv_r_id     = '0;
        slv_r_data   = '0;
        slv_r_resp   = RESP_OKAY;
        slv_r_last   = 1'b0;
        slv_r_user   = '0;
        mst_ar_valid = '0;
        mst_r_ready  = '0;
        def_ar_valid = 1'b0;
        def_r_ready  = 1'b0;
        if (rst_n) begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_dec == DEF_IDX) begin
                        def_ar_valid = slv_ar_valid;
                        slv_ar_ready = def_ar_ready;
                    end
                    for (int i = 0; i < NB_MASTER; i++) begin
                        if (ar_dec == IDX_W'(i)) begin
                            mst_ar_valid[i] = slv_ar_valid;
                            slv_ar_ready    = mst_ar_ready[i];
                        end
                    end
                end
                R_DATA: begin
                    if (r_idx_q == DEF_IDX) begin
                        def_r_ready = slv_r_ready;
                        slv_r_valid = def_r_valid;
                        slv_r_id    = def_r_id;
                        slv_r_data  = def_r_data;
                        slv_r_resp  = def_r_resp;
                        slv_r_last  = def_r_last;
                    end
                    for (int i = 0; i < NB_MASTER; i++) begin
                        if (r_idx_q == IDX_W'(i)) begin
                            mst_r_ready[i] = slv_r_ready;
                            slv_r_valid    = mst_r_valid[i];
                            slv_r_id       = mst_r_id[i];
                            slv_r_data     = mst_r_data[i];
                            slv_r_resp     = mst_r_resp[i];
                            slv_r_last     = mst_r_last[i];
                            slv_r_user     = mst_r_user[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit 16 of the widened sum flags overflow, covering the +2 case too.
    always_comb begin
        cnt_sum      = {1'b0, decerr_cnt_q} + 17'(def_b_done) + 17'(def_r_done);
        decerr_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    assign decerr_cnt_o = decerr_cnt_q;

    axi_default_slave #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .AXI_ID_WIDTH   (AXI_ID_WIDTH)
    ) u_default_slave (
        .clk      (clk),
        .rst_n    (rst_n),
        .aw_id    (slv_aw_id),
        .aw_valid (def_aw_valid),
        .aw_ready (def_aw_ready),
        .w_last   (slv_w_last),
        .w_valid  (def_w_valid),
        .w_ready  (def_w_ready),
        .b_id     (def_b_id),
        .b_resp   (def_b_resp),
        .b_valid  (def_b_valid),
        .b_ready  (def_b_ready),
        .ar_id    (slv_ar_id),
        .ar_len   (slv_ar_len),
        .ar_valid (def_ar_valid),
        .ar_ready (def_ar_ready),
        .r_id     (def_r_id),
        .r_data   (def_r_data),
        .r_resp   (def_r_resp),
        .r_last   (def_r_last),
        .r_valid  (def_r_valid),
        .r_ready  (def_r_ready),
        .b_done_o (def_b_done),
        .r_done_o (def_r_done)
    );

endmodule

// File: tb/tb_axi_region_demux.sv
// Directed bench for axi_region_demux: routed writes/reads, DECERR handling,
// concurrent traffic and asynchronous reset recovery.
module tb_axi_region_demux;

    logic              clk;
    logic              rst_n;
    logic [2:0]        slv_aw_id, slv_aw_size, slv_aw_prot;
    logic [31:0]       slv_aw_addr;
    logic [7:0]        slv_aw_len;
    logic [1:0]        slv_aw_burst;
    logic [0:0]        slv_aw_user;
    logic              slv_aw_valid, slv_aw_ready;
    logic [31:0]       slv_w_data;
    logic [3:0]        slv_w_strb;
    logic              slv_w_last;
    logic [0:0]        slv_w_user;
    logic              slv_w_valid, slv_w_ready;
    logic [2:0]        slv_b_id;
    logic [1:0]        slv_b_resp;
    logic [0:0]        slv_b_user;
    logic              slv_b_valid, slv_b_ready;
    logic [2:0]        slv_ar_id, slv_ar_size, slv_ar_prot;
    logic [31:0]       slv_ar_addr;
    logic [7:0]        slv_ar_len;
    logic [1:0]        slv_ar_burst;
    logic [0:0]        slv_ar_user;
    logic              slv_ar_valid, slv_ar_ready;
    logic [2:0]        slv_r_id;
    logic [31:0]       slv_r_data;
    logic [1:0]        slv_r_resp;
    logic              slv_r_last;
    logic [0:0]        slv_r_user;
    logic              slv_r_valid, slv_r_ready;
    logic [2:0][2:0]   mst_aw_id, mst_aw_size, mst_aw_prot;
    logic [2:0][31:0]  mst_aw_addr;
    logic [2:0][7:0]   mst_aw_len;
    logic [2:0][1:0]   mst_aw_burst;
    logic [2:0][0:0]   mst_aw_user;
    logic [2:0]        mst_aw_valid, mst_aw_ready;
    logic [2:0][31:0]  mst_w_data;
    logic [2:0][3:0]   mst_w_strb;
    logic [2:0]        mst_w_last;
    logic [2:0][0:0]   mst_w_user;
    logic [2:0]        mst_w_valid, mst_w_ready;
    logic [2:0][2:0]   mst_b_id;
    logic [2:0][1:0]   mst_b_resp;
    logic [2:0][0:0]   mst_b_user;
    logic [2:0]        mst_b_valid, mst_b_ready;
    logic [2:0][2:0]   mst_ar_id, mst_ar_size, mst_ar_prot;
    logic [2:0][31:0]  mst_ar_addr;
    logic [2:0][7:0]   mst_ar_len;
    logic [2:0][1:0]   mst_ar_burst;
    logic [2:0][0:0]   mst_ar_user;
    logic [2:0]        mst_ar_valid, mst_ar_ready;
    logic [2:0][2:0]   mst_r_id;
    logic [2:0][31:0]  mst_r_data;
    logic [2:0][1:0]   mst_r_resp;
    logic [2:0]        mst_r_last;
    logic [2:0][0:0]   mst_r_user;
    logic [2:0]        mst_r_valid, mst_r_ready;
    logic [95:0]       start_addr_i, end_addr_i;
    logic [15:0]       decerr_cnt_o;

    int check_count = 0;
    int pass_count  = 0;

    axi_region_demux dut (
        .clk(clk), .rst_n(rst_n),
        .slv_aw_id(slv_aw_id), .slv_aw_addr(slv_aw_addr), .slv_aw_len(slv_aw_len),
        .slv_aw_size(slv_aw_size), .slv_aw_burst(slv_aw_burst), .slv_aw_prot(slv_aw_prot),
        .slv_aw_user(slv_aw_user), .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready),
        .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb), .slv_w_last(slv_w_last),
        .slv_w_user(slv_w_user), .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready),
        .slv_b_id(slv_b_id), .slv_b_resp(slv_b_resp), .slv_b_user(slv_b_user),
        .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
        .slv_ar_id(slv_ar_id), .slv_ar_addr(slv_ar_addr), .slv_ar_len(slv_ar_len),
        .slv_ar_size(slv_ar_size), .slv_ar_burst(slv_ar_burst), .slv_ar_prot(slv_ar_prot),
        .slv_ar_user(slv_ar_user), .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
        .slv_r_id(slv_r_id), .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp),
        .slv_r_last(slv_r_last), .slv_r_user(slv_r_user), .slv_r_valid(slv_r_valid),
        .slv_r_ready(slv_r_ready),
        .mst_aw_id(mst_aw_id), .mst_aw_addr(mst_aw_addr), .mst_aw_len(mst_aw_len),
        .mst_aw_size(mst_aw_size), .mst_aw_burst(mst_aw_burst), .mst_aw_prot(mst_aw_prot),
        .mst_aw_user(mst_aw_user), .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
        .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb), .mst_w_last(mst_w_last),
        .mst_w_user(mst_w_user), .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
        .mst_b_id(mst_b_id), .mst_b_resp(mst_b_resp), .mst_b_user(mst_b_user),
        .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready),
        .mst_ar_id(mst_ar_id), .mst_ar_addr(mst_ar_addr), .mst_ar_len(mst_ar_len),
        .mst_ar_size(mst_ar_size), .mst_ar_burst(mst_ar_burst), .mst_ar_prot(mst_ar_prot),
        .mst_ar_user(mst_ar_user), .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
        .mst_r_id(mst_r_id), .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp),
        .mst_r_last(mst_r_last), .mst_r_user(mst_r_user), .mst_r_valid(mst_r_valid),
        .mst_r_ready(mst_r_ready),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .decerr_cnt_o(decerr_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Let the currently driven inputs be sampled by one rising edge, then
    // return at the falling edge where the next vector is driven.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearAll();
        slv_aw_id = '0; slv_aw_addr = '0; slv_aw_len = '0; slv_aw_size = 3'd2;
        slv_aw_burst = 2'b01; slv_aw_prot = '0; slv_aw_user = '0; slv_aw_valid = 1'b0;
        slv_w_data = '0; slv_w_strb = 4'hF; slv_w_last = 1'b0; slv_w_user = '0;
        slv_w_valid = 1'b0; slv_b_ready = 1'b0;
        slv_ar_id = '0; slv_ar_addr = '0; slv_ar_len = '0; slv_ar_size = 3'd2;
        slv_ar_burst = 2'b01; slv_ar_prot = '0; slv_ar_user = '0; slv_ar_valid = 1'b0;
        slv_r_ready = 1'b0;
        mst_aw_ready = '0; mst_w_ready = '0; mst_ar_ready = '0;
        mst_b_id = '0; mst_b_resp = '0; mst_b_user = '0; mst_b_valid = '0;
        mst_r_id = '0; mst_r_data = '0; mst_r_resp = '0; mst_r_last = '0;
        mst_r_user = '0; mst_r_valid = '0;
    endtask

    logic        gap_pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_data;
    int          beat;

    initial begin
        clearAll();
        start_addr_i = {32'h2100_0000, 32'h1013_0000, 32'h1000_0000};
        end_addr_i   = {32'h2100_FFFF, 32'h1013_FFFF, 32'h1003_FFFF};
        rst_n = 1'b0;
        @(negedge clk);
        slv_aw_valid = 1'b1;
        slv_aw_addr  = 32'h1000_0010;
        slv_ar_valid = 1'b1;
        mst_aw_ready = 3'b111;
        #1;
        checkOutput("rst_handshakes", {slv_aw_ready, slv_ar_ready, slv_w_ready,
                                       slv_b_valid, slv_r_valid}, 5'b0);
        checkOutput("rst_mst_aw_valid", mst_aw_valid, 3'b000);
        checkOutput("rst_cnt", decerr_cnt_o, 16'd0);
        @(negedge clk);
        clearAll();
        rst_n = 1'b1;

        // Routed single-beat write to region 0.
        slv_aw_id = 3'd3; slv_aw_addr = 32'h1000_0010; slv_aw_valid = 1'b1;
        mst_aw_ready = 3'b001;
        #1;
        checkOutput("wr0_aw_valid", mst_aw_valid, 3'b001);
        checkOutput("wr0_aw_addr", mst_aw_addr[0], 32'h1000_0010);
        checkOutput("wr0_aw_ready", slv_aw_ready, 1'b1);
        applyStimulus();
        clearAll();
        slv_w_data = 32'hDEAD_BEEF; slv_w_last = 1'b1; slv_w_valid = 1'b1;
        mst_w_ready = 3'b001;
        #1;
        checkOutput("wr0_w_valid", mst_w_valid, 3'b001);
        checkOutput("wr0_w_data", mst_w_data[0], 32'hDEAD_BEEF);
        checkOutput("wr0_w_ready", slv_w_ready, 1'b1);
        applyStimulus();
        clearAll();
        mst_b_valid = 3'b001; mst_b_id[0] = 3'd3; mst_b_resp[0] = 2'b00;
        mst_b_resp[1] = 2'b10; slv_b_ready = 1'b1;
        #1;
        checkOutput("wr0_b", {slv_b_valid, slv_b_id, slv_b_resp}, {1'b1, 3'd3, 2'b00});
        checkOutput("wr0_b_ready", mst_b_ready, 3'b001);
        applyStimulus();
        clearAll();
        #1;
        checkOutput("wr0_cnt", decerr_cnt_o, 16'd0);

        // 4-beat read from region 1 with gaps in r_valid.
        slv_ar_id = 3'd5; slv_ar_addr = 32'h1013_0000; slv_ar_len = 8'd3;
        slv_ar_valid = 1'b1; mst_ar_ready = 3'b010;
        #1;
        checkOutput("rd1_ar_valid", mst_ar_valid, 3'b010);
        checkOutput("rd1_ar_ready", slv_ar_ready, 1'b1);
        applyStimulus();
        clearAll();
        beat = 0;
        for (int c = 0; c < 7; c++) begin
            exp_data       = 32'hA0 + 32'(beat);
            slv_r_ready    = 1'b1;
            mst_r_valid    = gap_pat[c] ? 3'b010 : 3'b000;
            mst_r_data[1]  = exp_data;
            mst_r_id[1]    = 3'd5;
            mst_r_last[1]  = (beat == 3);
            #1;
            checkOutput("rd1_valid", slv_r_valid, gap_pat[c]);
            if (gap_pat[c]) begin
                checkOutput("rd1_beat", {slv_r_data, slv_r_id, slv_r_last},
                            {exp_data, 3'd5, (beat == 3)});
                beat++;
            end
            applyStimulus();
        end
        clearAll();
        slv_r_ready = 1'b1;
        #1;
        checkOutput("rd1_done", mst_r_ready, 3'b000);
        applyStimulus();
        clearAll();

        // Unmapped 8-beat read -> default slave.
        slv_ar_id = 3'd6; slv_ar_addr = 32'h3000_0000; slv_ar_len = 8'd7;
        slv_ar_valid = 1'b1; mst_ar_ready = 3'b111;
        #1;
        checkOutput("dr_ar", {mst_ar_valid, slv_ar_ready}, {3'b000, 1'b1});
        applyStimulus();
        clearAll();
        for (int k = 0; k < 8; k++) begin
            slv_r_ready = 1'b1;
            #1;
            checkOutput("dr_beat", {slv_r_valid, slv_r_data, slv_r_resp, slv_r_id, slv_r_last},
                        {1'b1, 32'h0, 2'b11, 3'd6, (k == 7)});
            applyStimulus();
        end
        clearAll();
        #1;
        checkOutput("dr_cnt", decerr_cnt_o, 16'd1);
        checkOutput("dr_idle", slv_ar_ready, 1'b1);

        // Unmapped 3-beat write with W presented before AW.
        slv_w_valid = 1'b1; slv_w_data = 32'h1111_1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("dw_w_stall", slv_w_ready, 1'b0);
            applyStimulus();
        end
        slv_aw_id = 3'd2; slv_aw_addr = 32'h0; slv_aw_len = 8'd2; slv_aw_valid = 1'b1;
        #1;
        checkOutput("dw_aw", {slv_aw_ready, slv_w_ready, mst_aw_valid}, {1'b1, 1'b0, 3'b000});
        applyStimulus();
        slv_aw_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            slv_w_last = (k == 2);
            #1;
            checkOutput("dw_w", {slv_w_ready, mst_w_valid}, {1'b1, 3'b000});
            applyStimulus();
        end
        slv_w_valid = 1'b0; slv_w_last = 1'b0; slv_b_ready = 1'b1;
        #1;
        checkOutput("dw_b", {slv_b_valid, slv_b_id, slv_b_resp}, {1'b1, 3'd2, 2'b11});
        applyStimulus();
        clearAll();
        #1;
        checkOutput("dw_cnt", decerr_cnt_o, 16'd2);

        // Read from region 0 stalled by r_ready while a write to region 2 completes.
        slv_aw_id = 3'd4; slv_aw_addr = 32'h2100_0040; slv_aw_valid = 1'b1;
        slv_ar_id = 3'd1; slv_ar_addr = 32'h1000_0100; slv_ar_valid = 1'b1;
        mst_aw_ready = 3'b100; mst_ar_ready = 3'b001;
        #1;
        checkOutput("cc_a", {mst_aw_valid, mst_ar_valid}, {3'b100, 3'b001});
        applyStimulus();
        clearAll();
        mst_r_valid = 3'b001; mst_r_data[0] = 32'h55; mst_r_id[0] = 3'd1; mst_r_last[0] = 1'b1;
        slv_w_data = 32'hCAFE; slv_w_last = 1'b1; slv_w_valid = 1'b1; mst_w_ready = 3'b100;
        #1;
        checkOutput("cc_w", {mst_w_valid, slv_w_ready}, {3'b100, 1'b1});
        checkOutput("cc_r_hold", {slv_r_valid, mst_r_ready}, {1'b1, 3'b000});
        applyStimulus();
        slv_w_valid = 1'b0; slv_w_last = 1'b0; mst_w_ready = '0;
        mst_b_valid = 3'b100; mst_b_id[2] = 3'd4; slv_b_ready = 1'b1;
        #1;
        checkOutput("cc_b", {slv_b_valid, slv_b_id, slv_b_resp, mst_b_ready},
                    {1'b1, 3'd4, 2'b00, 3'b100});
        applyStimulus();
        mst_b_valid = '0; slv_b_ready = 1'b0;
        slv_aw_addr = 32'h2100_0040; mst_aw_ready = 3'b100;
        #1;
        checkOutput("cc_w_idle", slv_aw_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("cc_r_hold", {slv_r_valid, mst_r_ready}, {1'b1, 3'b000});
            applyStimulus();
        end
        slv_r_ready = 1'b1;
        #1;
        checkOutput("cc_r", {slv_r_valid, slv_r_data, slv_r_id, slv_r_last, mst_r_ready},
                    {1'b1, 32'h55, 3'd1, 1'b1, 3'b001});
        applyStimulus();
        clearAll();

        // Default B and default R-last in the same cycle count twice.
        slv_aw_id = 3'd1; slv_aw_addr = 32'h0; slv_aw_valid = 1'b1;
        slv_ar_id = 3'd7; slv_ar_addr = 32'h0400_0000; slv_ar_valid = 1'b1;
        #1;
        checkOutput("d2_addr", {slv_aw_ready, slv_ar_ready}, 2'b11);
        applyStimulus();
        clearAll();
        slv_w_valid = 1'b1; slv_w_last = 1'b1;
        #1;
        checkOutput("d2_w", {slv_w_ready, slv_r_valid}, 2'b11);
        applyStimulus();
        clearAll();
        slv_b_ready = 1'b1; slv_r_ready = 1'b1;
        #1;
        checkOutput("d2_both", {slv_b_valid, slv_r_valid, slv_r_last, slv_r_id}, {3'b111, 3'd7});
        applyStimulus();
        clearAll();
        #1;
        checkOutput("d2_cnt", decerr_cnt_o, 16'd4);

        // Asynchronous reset in the middle of a default-slave read.
        slv_ar_id = 3'd2; slv_ar_addr = 32'h3000_0000; slv_ar_len = 8'd3; slv_ar_valid = 1'b1;
        applyStimulus();
        clearAll();
        #1;
        checkOutput("rr_pre", slv_r_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        slv_aw_valid = 1'b1; slv_aw_addr = 32'h1000_0010; mst_aw_ready = 3'b001;
        #1;
        checkOutput("rr_async", {slv_r_valid, slv_ar_ready, slv_aw_ready, mst_aw_valid},
                    {3'b000, 3'b000});
        checkOutput("rr_cnt", decerr_cnt_o, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clearAll();
        slv_ar_id = 3'd3; slv_ar_addr = 32'h2100_0100; slv_ar_valid = 1'b1;
        mst_ar_ready = 3'b100;
        #1;
        checkOutput("rr_ar", {mst_ar_valid, slv_ar_ready}, {3'b100, 1'b1});
        applyStimulus();
        clearAll();
        mst_r_valid = 3'b100; mst_r_data[2] = 32'h77; mst_r_id[2] = 3'd3; mst_r_last[2] = 1'b1;
        slv_r_ready = 1'b1;
        #1;
        checkOutput("rr_r", {slv_r_valid, slv_r_data, slv_r_id, slv_r_last, slv_r_resp, mst_r_ready},
                    {1'b1, 32'h77, 3'd3, 1'b1, 2'b00, 3'b100});
        applyStimulus();
        clearAll();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/axi_region_demux.md
# axi_region_demux

Parametrised AXI4 one-to-N address demultiplexer with an integrated default slave. It sits between one upstream AXI master port and NB_MASTER downstream slave regions, each defined by an inclusive start/end address pair. It routes full bursts and keeps reads and writes independent. Unmapped accesses get a DECERR response and are counted.

## Interface
- NB_MASTER, 3, number of downstream regions
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width
- AXI_ID_WIDTH, 3, ID width, passed through unchanged
- AXI_USER_WIDTH, 1, user width, passed through unchanged

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- slv  AXI_BUS.Slave  —  upstream port
- mst[NB_MASTER-1:0]  AXI_BUS.Master  —  downstream ports; index i serves region i
- start_addr_i  in  NB_MASTER*AXI_ADDR_WIDTH  region start addresses, inclusive; region 0 occupies the LSBs
- end_addr_i  in  NB_MASTER*AXI_ADDR_WIDTH  region end addresses, inclusive; same packing as start_addr_i
- decerr_cnt_o  out  16  saturating count of DECERR transactions (writes plus reads)

## Operation
- Decode: region i hits when start_i <= addr <= end_i (unsigned). When regions overlap, the lowest index wins. No hit selects the default slave.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: slv AW is forwarded combinationally to the decoded target. aw_valid goes only to that target; slv.aw_ready comes from that target. On the AW handshake the target index is latched and the FSM moves to W_DATA.
  - W_DATA: W is routed to the latched target. The W handshake with w_last moves the FSM to W_RESP.
  - W_RESP: B is routed from the latched target. The B handshake returns the FSM to W_IDLE.
  - slv.w_ready is 0 outside W_DATA. W data arriving before AW is stalled, never dropped.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: AR is forwarded the same way as AW. On the AR handshake the index is latched and the FSM moves to R_DATA.
  - R_DATA: R is routed from the latched target. The handshake with r_last returns the FSM to R_IDLE.
- Default slave:
  - Accepts AW/AR immediately (ready=1 in the idle state).
  - Writes: w_ready=1 in W_DATA and data is discarded. After w_last, one B beat is returned with b_resp=2'b11 and b_id set to the captured ID.
  - Reads: returns ARLEN+1 beats with r_data=0, r_resp=2'b11, r_id set to the captured ID, and r_last on the final beat. A beat counter is loaded with ARLEN and decremented on each handshake.
- decerr_cnt_o increments by 1 on each default-slave B handshake and each default-slave R handshake with r_last. It saturates at 16'hFFFF. When both complete in the same cycle it increments by 2, still saturating.
- Unselected downstream ports see all valid/ready signals at 0.

## Timing
- Routed paths add zero cycles: address, data and response are all combinational through the mux.
- Default slave:
  - B valid appears the cycle after the w_last handshake.
  - The first R beat appears the cycle after the AR handshake. One beat per cycle follows while r_ready=1.
- Outstanding transactions: one write and one read at a time. A second AW is not accepted until B completes. A second AR is not accepted until r_last completes.
- A write and a read may be in flight to the same or different regions at the same time.
- Reset values:
  - FSMs in W_IDLE/R_IDLE, latched indices 0, beat counter 0, decerr_cnt_o 0.
  - While rst_n is low, every valid/ready output on slv and mst is 0.
- Reset mid-burst aborts the transaction. Downstream and upstream recovery is the system's responsibility.
- end < start defines an empty region, which is never hit.

## Structure
- Package axi_region_demux_pkg holds:
  - RESP_OKAY=2'b00 and RESP_DECERR=2'b11
  - the write and read FSM enum typedefs
- Sub-module axi_default_slave holds the DECERR responder: write path, read beat counter and completion pulses.
- The top level holds the decoder, the FSMs, the muxes and the counter.

## Test plan
- Use map {0x2100_0000–0x2100_FFFF, 0x1013_0000–0x1013_FFFF, 0x1000_0000–0x1003_FFFF} as regions 2, 1, 0:
  - write 0xDEADBEEF to 0x1000_0010 -> mst[0] receives it; B OKAY with the same ID; decerr_cnt_o stays 0.
  - 4-beat read (ARLEN=3, ID=5) at 0x1013_0000 while mst[1] inserts r_valid gaps -> all 4 beats arrive in order; r_last on beat 4 only.
- Read ARLEN=7 at 0x3000_0000 -> 8 beats, data 0, resp DECERR, ID echoed; decerr_cnt_o=1.
- Write ARLEN... AWLEN=2 to 0x0000_0000 with W presented 3 cycles before AW -> w_ready stays 0 until AW completes; B DECERR; counter 2.
- Concurrent read from region 0 and write to region 2 with r_ready held low 5 cycles -> the write completes independently.
- Assert rst_n low mid-read -> all valids drop to 0 asynchronously; after release a fresh read succeeds.
